// File: rtl/actuator_scheduler.sv
// Shares one extinguisher valve/pump driver among four requesters. Each grant runs ARM -> FIRE -> COOL,
// with a minimum on-time, a cool-down gap and a watchdog. Build option ROUND_ROBIN_EN selects rotating priority.
module actuator_scheduler #(
   parameter int ON_TICKS   = 4,
   parameter int COOL_TICKS = 2,
   parameter int MAX_TICKS  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [3:0] req,
   input  logic       clr_fault,
   output logic [3:0] grant,
   output logic       valve_on,
   output logic [1:0] active_id,
   output logic       busy,
   output logic       fault
);

   localparam int CW = $clog2(MAX_TICKS + 1);
   localparam logic [CW-1:0] ON_C   = CW'(ON_TICKS);
   localparam logic [CW-1:0] COOL_C = CW'(COOL_TICKS);
   localparam logic [CW-1:0] MAX_C  = CW'(MAX_TICKS);

   typedef enum logic [1:0] {IDLE, ARM, FIRE, COOL} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [3:0]    grant_nxt;
   logic [1:0]    id_nxt;
   logic          fault_nxt;
   logic [1:0]    win;
   logic          win_vld;
   logic          preempt;
   logic          release_req;
   logic          timeout;

`ifdef ROUND_ROBIN_EN
   logic [1:0] rr_ptr, rr_ptr_nxt;
   logic [1:0] idx;

   // Descending scan so the requester closest to the pointer is written last.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int i = 3; i >= 0; i--) begin
         idx = rr_ptr + 2'(i);
         if (req[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

   assign preempt = |(req & ~grant);
`else
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (req[i]) begin
            win     = 2'(i);
            win_vld = 1'b1;
         end
      end
   end

   // Any requester with a lower index than the holder outranks it.
   assign preempt = |(req & ((4'b0001 << active_id) - 4'b0001));
`endif

   assign release_req = ~req[active_id] | preempt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      grant_nxt = grant;
      id_nxt    = active_id;
      timeout   = 1'b0;
      fault_nxt = clr_fault ? 1'b0 : fault;
`ifdef ROUND_ROBIN_EN
      rr_ptr_nxt = rr_ptr;
`endif
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (win_vld) begin
               state_nxt = ARM;
               grant_nxt = 4'b0001 << win;
               id_nxt    = win;
`ifdef ROUND_ROBIN_EN
               rr_ptr_nxt = win + 2'd1;
`endif
            end
         end
         ARM: begin
            // The clear wins over a tick landing on this edge.
            state_nxt = FIRE;
            cnt_nxt   = '0;
         end
         FIRE: begin
            if (cnt == MAX_C) begin
               timeout   = 1'b1;
               state_nxt = COOL;
            end else if (cnt >= ON_C && release_req) begin
               state_nxt = COOL;
            end else if (tick && cnt != MAX_C) begin
               cnt_nxt = cnt + CW'(1);
            end
            if (state_nxt == COOL) begin
               // COOL counts ticks, so a tick on the entry edge is its first.
               cnt_nxt   = tick ? CW'(1) : '0;
               grant_nxt = '0;
               id_nxt    = '0;
            end
         end
         COOL: begin
            if (cnt >= COOL_C) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (tick) begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            grant_nxt = '0;
            id_nxt    = '0;
         end
      endcase
      if (timeout)
         fault_nxt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         grant     <= '0;
         active_id <= '0;
         valve_on  <= 1'b0;
         busy      <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         grant     <= grant_nxt;
         active_id <= id_nxt;
         valve_on  <= (state_nxt == FIRE);
         busy      <= (state_nxt != IDLE);
         fault     <= fault_nxt;
      end
   end

`ifdef ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (!reset)
         rr_ptr <= '0;
      else
         rr_ptr <= rr_ptr_nxt;
   end
`endif

endmodule
